// File: rtl/pmem_line_responder.sv
// pmem_line_responder: line-granular backing memory that answers LC3B cache
// pmem_read/pmem_write requests with pmem_resp after a fixed LATENCY.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset (array contents retained)
//   pmem_address byte address; line index = pmem_address[IW+3:4]
//   pmem_read    line read request, held until pmem_resp
//   pmem_write   line write request, held until pmem_resp
//   pmem_wdata   128-bit write line
//   pmem_rdata   128-bit registered read line
//   pmem_resp    one-cycle completion strobe
//   proto_err    sticky protocol-violation flag
module pmem_line_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [127:0]    wdata_q, wdata_d;
  logic [127:0]    rdata_q, rdata_d;
  logic            perr_q, perr_d;

  logic [127:0]    mem_q [DEPTH];

  logic [IW-1:0]   addr_idx;
  logic [IW-1:0]   rd_idx;
  logic            req;
  logic            accept;
  logic            ld_rdata;
  logic            mem_we;
  logic            unused_addr;

  assign addr_idx    = pmem_address[IW+3:4];
  assign req         = pmem_read | pmem_write;
  assign accept      = (state_q == IDLE) & req;
  // Offset and alias bits are deliberately ignored.
  assign unused_addr = ^pmem_address;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Counter holds remaining BUSY cycles; leaving BUSY as it hits zero
  // places RESP in cycle accept+LATENCY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 8'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    if (accept) begin
      idx_d   = addr_idx;
      wr_d    = pmem_write;
      wdata_d = pmem_wdata;
    end
    // With LATENCY=1 the read is served on the accept edge itself,
    // before idx_q holds the new index.
    rd_idx   = (state_q == IDLE) ? addr_idx : idx_q;
    ld_rdata = (state_d == RESP) & (state_q != RESP) & ~wr_d;
    rdata_d  = ld_rdata ? mem_q[rd_idx] : rdata_q;
    perr_d   = perr_q
             | (accept & pmem_read & pmem_write)
             | ((state_q == BUSY) & req
                & ((pmem_write != wr_q) | (addr_idx != idx_q)));
    mem_we   = (state_q == RESP) & wr_q;
    pmem_resp  = (state_q == RESP);
    pmem_rdata = rdata_q;
    proto_err  = perr_q;
  end

  // Commit on the edge leaving RESP so a read accepted right after sees it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
